vga_text_ctrl: RTL
==================

# vga_text_ctrl

Text-mode scanout controller for the 640x480 VGA path. It turns the timing generator's pixel coordinates into character-RAM fetches and `pc_vga_8x16` ROM lookups, and emits a delay-aligned pixel with syncs. It also shares the single-port character RAM between display fetches and CPU writes, and overlays a blinking underline cursor.

## Interface
Parameters:
- COLS, 80, characters per text row
- ROWS, 30, text rows
- BLINK_FRAMES, 30, frames per cursor blink half-period

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  async active-low reset
- in_active  in  1  visible-region flag from timing generator
- in_hsync, in_vsync  in  1 each  syncs from timing generator
- in_x, in_y  in  10 each  pixel coordinates
- ram_addr  out  12  char RAM address (registered)
- ram_rd  out  1  display read strobe (registered)
- ram_we  out  1  CPU write strobe (registered)
- ram_wdata  out  8  write data (registered)
- ram_rdata  in  8  read data, valid 1 cycle after ram_rd
- cpu_req  in  1  write request, held until ack
- cpu_addr  in  12  write address
- cpu_wdata  in  8  write data
- cpu_ack  out  1  one-cycle grant pulse
- cursor_addr  in  12  cursor character index
- cursor_en  in  1  cursor enable
- rom_ascii  out  8  to font ROM
- rom_row  out  4  to font ROM
- rom_col  out  3  to font ROM
- rom_pixel  in  1  font ROM output, 1 cycle after inputs
- out_pixel, out_hsync, out_vsync, out_active  out  1 each  aligned outputs

## Operation
- Character index = (in_y[9:4])*COLS + in_x[9:3], 12-bit.
- A display fetch slot is any cycle N with in_active=1, in_x[2:0]=0, and in_x[9:3]<COLS. In slot N, the RAM port at N+1 carries ram_rd=1, ram_we=0, and ram_addr=index.
- Arbiter:
  - Display has fixed priority.
  - cpu_req sampled at N is granted when N is not a fetch slot and cpu_ack is low at N.
  - On grant, N+1 has ram_we=1, ram_addr=cpu_addr, ram_wdata=cpu_wdata, cpu_ack=1.
  - The no-grant rule while cpu_ack is high gives a one-cycle turnaround, so the maximum CPU rate is one write per 2 cycles.
  - Idle RAM port: ram_rd=ram_we=0, ram_addr holds its value.
- ROM drive at N+2 (registered, so ROM output is at N+3):
  - rom_ascii = ram_rdata when the delayed x[2:0]=0, else the held char register.
  - The char register loads ram_rdata in every fetch-return cycle.
  - rom_row = delayed y[3:0]; rom_col = delayed x[2:0].
- Cursor:
  - The pipelined cursor hit is set when index==cursor_addr, cursor_en=1, blink phase=1, and y[3:0]>=14.
  - The hit inverts rom_pixel.
- Blink:
  - A frame counter increments on each in_vsync rising edge.
  - At BLINK_FRAMES-1 it wraps to 0 and toggles the phase.
- out_pixel = (rom_pixel XOR cursor hit) AND the delayed active flag.
- Out-of-range columns (in_x[9:3]>=COLS) while in_active: no fetch, out_pixel=0.

## Timing
- Latency from in_* at cycle N to out_* at N+4. Syncs and active pass through a 4-stage shift register.
- Reset (async, rst_n=0):
  - All outputs are 0; ram_addr=0.
  - Char register, frame counter and blink phase are cleared. Phase 0 means the cursor is off for the first BLINK_FRAMES frames.
- Reset in mid-write: the write is dropped and cpu_ack is not issued. The CPU must re-request.
- cpu_req rising in a fetch slot: the grant defers to the next non-slot cycle (at most 1 cycle during active, since slots are 1-in-8).
- A simultaneous vsync edge and counter wrap produce a single toggle.
- Blanking: no fetches; every non-turnaround cycle is grantable.

## Test plan
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Release -> out_* equals in_* delayed 4 cycles.
- Scanout: RAM model with index 0 = 0x41 and glyph row pattern 0x18. Sweep in_x 0..7 at in_y=0 -> ram_rd at x=0 plus 1 cycle with ram_addr=0; rom_ascii=0x41 for 8 cycles; out_pixel follows 0,0,0,1,1,0,0,0 with 4-cycle latency.
- Addressing: in_y=17, in_x=24 -> ram_addr=1*80+3=83. in_x=640 with in_active forced -> no ram_rd, out_pixel=0.
- Arbitration: cpu_req at x=8 (slot) with addr 0x123, data 0x5A -> ram_we at x=9 plus 1, cpu_ack one pulse. Request held continuously -> writes spaced 2 cycles apart during blanking.
- Cursor: cursor_addr=0, cursor_en=1, BLINK_FRAMES=2 -> rows 14-15 of char 0 inverted only in frames 2-3, 6-7 and so on; no inversion with cursor_en=0.
- Mid-write reset: assert rst_n=0 in the cycle after the grant decision -> no cpu_ack; ram_we=0 throughout reset.

Source files
------------

// File: rtl/vga_text_ctrl.sv
// rtl/vga_text_ctrl.sv - text-mode VGA scanout: char RAM fetch/CPU arbitration, font ROM drive, blinking cursor
// Every path from in_* to out_* is four registers deep so pixels stay aligned with the syncs.
module vga_text_ctrl #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_active,
  input  logic        in_hsync,
  input  logic        in_vsync,
  input  logic [9:0]  in_x,
  input  logic [9:0]  in_y,
  output logic [11:0] ram_addr,
  output logic        ram_rd,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  input  logic        cpu_req,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  input  logic [11:0] cursor_addr,
  input  logic        cursor_en,
  output logic [7:0]  rom_ascii,
  output logic [3:0]  rom_row,
  output logic [2:0]  rom_col,
  input  logic        rom_pixel,
  output logic        out_pixel,
  output logic        out_hsync,
  output logic        out_vsync,
  output logic        out_active
);

  localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [6:0]     col;
  logic [5:0]     row;
  logic [11:0]    char_idx;
  logic           cell_ok;
  logic           slot;
  logic           grant;
  logic           hit_now;

  logic [FCW-1:0] frame_cnt;
  logic           blink_phase;
  logic           vsync_q;

  logic [2:0]     hs_d;
  logic [2:0]     vs_d;
  logic [2:0]     act_d;
  logic [2:0]     vis_d;
  logic [2:0]     hit_d;
  logic [2:0]     x_d1;
  logic [3:0]     y_d1;
  logic           fetch_ret;
  logic [7:0]     char_q;

  assign col      = in_x[9:3];
  assign row      = in_y[9:4];
  assign char_idx = 12'(int'(row) * COLS + int'(col));
  assign cell_ok  = (int'(col) < COLS) && (int'(row) < ROWS);
  assign slot     = in_active && (in_x[2:0] == 3'd0) && cell_ok;
  // No grant in the ack cycle: forces a one-cycle turnaround between CPU writes.
  assign grant    = cpu_req && !slot && !cpu_ack;
  assign hit_now  = cursor_en && blink_phase && (char_idx == cursor_addr) &&
                    (in_y[3:0] >= 4'd14);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr  <= '0;
      ram_rd    <= 1'b0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      cpu_ack   <= 1'b0;
    end else begin
      ram_rd  <= slot;
      ram_we  <= grant;
      cpu_ack <= grant;
      if (slot) begin
        ram_addr <= char_idx;
      end else if (grant) begin
        ram_addr  <= cpu_addr;
        ram_wdata <= cpu_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      vsync_q     <= 1'b0;
    end else begin
      vsync_q <= in_vsync;
      if (in_vsync && !vsync_q) begin
        if (frame_cnt == FCW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_d      <= '0;
      vs_d      <= '0;
      act_d     <= '0;
      vis_d     <= '0;
      hit_d     <= '0;
      x_d1      <= '0;
      y_d1      <= '0;
      rom_col   <= '0;
      rom_row   <= '0;
      fetch_ret <= 1'b0;
      char_q    <= '0;
    end else begin
      hs_d      <= {hs_d[1:0], in_hsync};
      vs_d      <= {vs_d[1:0], in_vsync};
      act_d     <= {act_d[1:0], in_active};
      vis_d     <= {vis_d[1:0], in_active && cell_ok};
      hit_d     <= {hit_d[1:0], hit_now};
      x_d1      <= in_x[2:0];
      y_d1      <= in_y[3:0];
      rom_col   <= x_d1;
      rom_row   <= y_d1;
      fetch_ret <= ram_rd;
      if (fetch_ret) begin
        char_q <= ram_rdata;
      end
    end
  end

  // Fetched byte goes straight to the ROM in its return cycle; the rest of the cell uses the held copy.
  assign rom_ascii = fetch_ret ? ram_rdata : char_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pixel  <= 1'b0;
      out_hsync  <= 1'b0;
      out_vsync  <= 1'b0;
      out_active <= 1'b0;
    end else begin
      out_pixel  <= (rom_pixel ^ hit_d[2]) & vis_d[2];
      out_hsync  <= hs_d[2];
      out_vsync  <= vs_d[2];
      out_active <= act_d[2];
    end
  end

endmodule
